// File: rtl/easyaxi_test_seq.sv
// Multi-channel enable/done test sequencer for EasyAXI bring-up.
// Runs NUM_RUNS enable pulses with a per-run watchdog and cycle count.
module easyaxi_test_seq #(
  parameter int NUM_CH    = 1,
  parameter int NUM_RUNS  = 1,
  parameter int START_DLY = 5,
  parameter int DRAIN_DLY = 20,
  parameter int TIMEOUT   = 1000,
  parameter int CNT_W     = 16,
  parameter int RUN_W     = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] ch_done,
  output logic [NUM_CH-1:0] ch_enable,
  output logic              busy,
  output logic              finish,
  output logic              pass,
  output logic              timeout,
  output logic [RUN_W-1:0]  run_idx,
  output logic [CNT_W-1:0]  run_cycles
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DELAY,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam logic [CNT_W-1:0] START_M1 = CNT_W'(START_DLY - 1);
  localparam logic [CNT_W-1:0] DRAIN_M1 = CNT_W'(DRAIN_DLY - 1);
  localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TIMEOUT - 1);
  localparam logic [RUN_W-1:0] RUNS_M1  = RUN_W'(NUM_RUNS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  wdog;
  logic [NUM_CH-1:0] mask_q;
  logic [NUM_CH-1:0] done_seen;
  logic [NUM_CH-1:0] done_now;
  logic              all_done;
  logic [CNT_W-1:0]  wdog_inc;

  // Run completes once every masked channel has been seen done
  always_comb begin
    done_now = done_seen | (ch_done & mask_q);
    all_done = (done_now == mask_q);
    wdog_inc = (wdog == '1) ? wdog : wdog + CNT_ONE;
  end

  // Sequencer FSM; outputs registered alongside the state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      wdog       <= '0;
      mask_q     <= '0;
      done_seen  <= '0;
      ch_enable  <= '0;
      busy       <= 1'b0;
      finish     <= 1'b0;
      pass       <= 1'b0;
      timeout    <= 1'b0;
      run_idx    <= '0;
      run_cycles <= '0;
    end else begin
      unique case (state)
        S_IDLE, S_FINISH: begin
          if (start) begin
            state   <= S_DELAY;
            mask_q  <= ch_mask;
            run_idx <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            finish  <= 1'b0;
            pass    <= 1'b0;
            timeout <= 1'b0;
          end
        end
        S_DELAY: begin
          if (cnt == START_M1) begin
            state     <= S_RUN;
            done_seen <= '0;
            wdog      <= '0;
            ch_enable <= mask_q;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          if (all_done) begin
            state      <= S_DRAIN;
            ch_enable  <= '0;
            run_cycles <= wdog_inc;
            cnt        <= '0;
          end else if (wdog == TMO_M1) begin
            state     <= S_FINISH;
            ch_enable <= '0;
            busy      <= 1'b0;
            finish    <= 1'b1;
            timeout   <= 1'b1;
            pass      <= 1'b0;
          end else begin
            wdog      <= wdog + CNT_ONE;
            done_seen <= done_now;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_M1) begin
            if (run_idx == RUNS_M1) begin
              state  <= S_FINISH;
              busy   <= 1'b0;
              finish <= 1'b1;
              pass   <= 1'b1;
            end else begin
              state   <= S_DELAY;
              run_idx <= run_idx + RUN_ONE;
              cnt     <= '0;
            end
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
